bram_bist_sequencer: RTL



---
 rtl/bram_bist_sequencer_if.sv | 24 ++
 rtl/bram_bist_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bram_bist_sequencer_if.sv
// RAM-side bus between the BIST sequencer (master) and one single-port BRAM (slave).
interface bram_bist_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_addr,
        output mem_din,
        output mem_we,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_din,
        input  mem_we,
        output mem_dout
    );
endinterface

// File: rtl/bram_bist_sequencer.sv
// Write-all / read-all BIST sequencer for a single-port BRAM with a 1-cycle registered read.
// Define BIST_FIRST_FAIL_EN to capture the address and data of the first mismatch.
module bram_bist_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_count,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic [DATA_W-1:0]     first_fail_data,
    bram_bist_sequencer_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        pat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_exp;
    logic              mismatch;
    logic              addr_last;
    logic              accept;

    function automatic logic [DATA_W-1:0] pattern_of(input logic [1:0] sel,
                                                     input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] base;
        base = DATA_W'(a);
        case (sel)
            2'd0:    pattern_of = base;
            2'd1:    pattern_of = ~base;
            2'd2:    pattern_of = a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
            default: pattern_of = '1;
        endcase
    endfunction

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign addr_last = &addr_q;
    assign mismatch  = pipe_valid && (mem.mem_dout != pipe_exp);
    assign pass      = done && (err_count == '0);

    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = din_q;
    assign mem.mem_we   = we_q;

    // The read pipeline holds the expected word for the address the RAM is currently fetching,
    // so the compare lands one cycle after the address was issued (including the DRAIN cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pat_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            pipe_valid <= 1'b0;
            pipe_exp   <= '0;
        end else begin
            pipe_valid <= (state == S_READ);
            pipe_exp   <= pattern_of(pat_q, addr_q);
            if (mismatch) begin
                err_count <= err_count + 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state     <= S_WRITE;
                        pat_q     <= pattern_sel;
                        addr_q    <= '0;
                        din_q     <= pattern_of(pattern_sel, '0);
                        we_q      <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_count <= '0;
                    end
                end
                S_WRITE: begin
                    if (addr_last) begin
                        state  <= S_READ;
                        addr_q <= '0;
                        din_q  <= '0;
                        we_q   <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        din_q  <= pattern_of(pat_q, addr_q + 1'b1);
                    end
                end
                S_READ: begin
                    if (addr_last) begin
                        state <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BIST_FIRST_FAIL_EN
    logic [ADDR_W-1:0] pipe_addr;

    // err_count is still zero exactly when the first mismatch since the last start is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_addr       <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else begin
            pipe_addr <= addr_q;
            if (accept) begin
                first_fail_addr <= '0;
                first_fail_data <= '0;
            end else if (mismatch && (err_count == '0)) begin
                first_fail_addr <= pipe_addr;
                first_fail_data <= mem.mem_dout;
            end
        end
    end
`else
    assign first_fail_addr = '0;
    assign first_fail_data = '0;
`endif

endmodule
